// File: rtl/fetch_pkg.sv
// Shared widths, constants and FSM encoding for the instruction fetch controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_pkg;

  localparam int PC_W    = 10;
  localparam int INSTR_W = 32;
  localparam int OFF_W   = 20;

  // Sequential fetch advances one 32-bit word per instruction.
  localparam logic [PC_W-1:0] PC_STEP = 10'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    FLUSH = 2'd3
  } state_t;

endpackage

// File: rtl/fetch_if.sv
// Instruction memory request/response bundle between fetch controller and memory.
// Latency: n/a (wires only); responses may arrive any number of cycles after acceptance.
// Backpressure: memory stalls a request by holding imem_ready low.
// Ports: imem_req/imem_addr (request), imem_ready (accept), imem_rvalid/imem_rdata (response).
interface fetch_if;
  import fetch_pkg::*;

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ready;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;

  // Fetch controller side.
  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  // Instruction memory side.
  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/pc_next.sv
// Next fetch PC: sequential increment or branch target relative to the last delivered PC.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is loaded.
// Ports: pc, instr_pc, branch_offset, take_branch in; pc_nxt out.
module pc_next
  import fetch_pkg::*;
(
  input  logic [PC_W-1:0]  pc,
  input  logic [PC_W-1:0]  instr_pc,
  input  logic [OFF_W-1:0] branch_offset,
  input  logic             take_branch,
  output logic [PC_W-1:0]  pc_nxt
);

  // Only the low PC_W offset bits matter: the address space wraps at 1 KiB,
  // so the high bits can never change the result.
  logic unused_off_hi;
  assign unused_off_hi = ^branch_offset[OFF_W-1:PC_W];

  // Both sums wrap naturally at PC_W bits.
  assign pc_nxt = take_branch ? (instr_pc + branch_offset[PC_W-1:0])
                              : (pc + PC_STEP);

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding memory request, branch redirect with response flush.
// Latency: request issued from FETCH; instruction delivered the cycle after imem_rvalid is seen in WAIT.
// Backpressure: stall blocks new requests only; imem_ready low holds the request in FETCH.
// Ports: clk, reset (async active-low), stall, branch_req/branch_offset, mem (fetch_if.master),
//        instr_valid/instr/instr_pc (delivered instruction), pc (current fetch PC).
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 10'd0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               branch_req,
  input  logic [OFF_W-1:0]   branch_offset,
  fetch_if.master            mem,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  output logic [PC_W-1:0]    pc
);

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc_d;
  logic [PC_W-1:0] pc_calc;
  logic            take_branch;
  logic            capture;

  // Redirects are honoured in every state except IDLE. Kept outside the FSM
  // block so pc_next sees no path back through the same process.
  assign take_branch = branch_req && (state != IDLE);

  pc_next u_pc_next (
    .pc            (pc),
    .instr_pc      (instr_pc),
    .branch_offset (branch_offset),
    .take_branch   (take_branch),
    .pc_nxt        (pc_calc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr_pc    <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_d;
      instr_valid <= capture;
      if (capture) begin
        instr    <= mem.imem_rdata;
        instr_pc <= pc;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    pc_d          = pc;
    capture       = 1'b0;
    mem.imem_req  = 1'b0;
    mem.imem_addr = pc;

    unique case (state)
      IDLE: begin
        state_nxt = FETCH;
      end

      FETCH: begin
        // A redirect consumes the cycle; the new PC is fetched next cycle.
        if (take_branch) begin
          pc_d = pc_calc;
        end else if (!stall) begin
          mem.imem_req = 1'b1;
          if (mem.imem_ready) begin
            state_nxt = WAIT;
          end
        end
      end

      WAIT: begin
        // stall is deliberately ignored here: the response is already in flight.
        if (take_branch) begin
          pc_d      = pc_calc;
          // Response in the same cycle is dropped; otherwise it must be
          // swallowed later in FLUSH.
          state_nxt = mem.imem_rvalid ? FETCH : FLUSH;
        end else if (mem.imem_rvalid) begin
          capture   = 1'b1;
          pc_d      = pc_calc;
          state_nxt = FETCH;
        end
      end

      FLUSH: begin
        if (take_branch) begin
          pc_d = pc_calc;
        end
        if (mem.imem_rvalid) begin
          state_nxt = FETCH;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a latency-programmable memory model and
// address/instruction scoreboards.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  localparam logic [PC_W-1:0] RST_PC = 10'd0;

  logic               clk;
  logic               reset;
  logic               stall;
  logic               branch_req;
  logic [OFF_W-1:0]   branch_offset;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [PC_W-1:0]    instr_pc;
  logic [PC_W-1:0]    pc;

  fetch_if mem_if ();

  fetch_ctrl #(.RESET_PC(RST_PC)) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_req    (branch_req),
    .branch_offset (branch_offset),
    .mem           (mem_if),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .pc            (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [PC_W-1:0] exp_addr_q [$];
  logic [PC_W-1:0] exp_instr_q [$];

  function automatic logic [INSTR_W-1:0] mk_word(input logic [PC_W-1:0] a);
    return {a[5:0], 16'hBEEF, a};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory model: at negedge+1 (inputs settled) deliver any due response,
  // then record a request that will be accepted at the coming posedge.
  int              lat = 1;
  logic            pend = 1'b0;
  int              cnt = 0;
  logic [PC_W-1:0] paddr = '0;

  initial begin
    mem_if.imem_rvalid = 1'b0;
    mem_if.imem_rdata  = '0;
  end

  always begin
    @(negedge clk);
    #1;
    if (pend && cnt == 1) begin
      mem_if.imem_rvalid = 1'b1;
      mem_if.imem_rdata  = mk_word(paddr);
      pend = 1'b0;
    end else begin
      mem_if.imem_rvalid = 1'b0;
      if (pend) cnt--;
    end
    if (reset === 1'b1 && mem_if.imem_req === 1'b1 && mem_if.imem_ready === 1'b1) begin
      if (exp_addr_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_req: observed addr %0h expected no request", mem_if.imem_addr);
      end else begin
        check("req_addr", 32'(mem_if.imem_addr), 32'(exp_addr_q.pop_front()));
      end
      pend  = 1'b1;
      paddr = mem_if.imem_addr;
      cnt   = lat;
    end
  end

  // Delivery monitor: each strobe must match the oldest expected instruction
  // and never follow another strobe directly.
  logic prev_vld = 1'b0;
  always @(negedge clk) begin
    if (instr_valid === 1'b1) begin
      check("no_back_to_back", 32'(prev_vld), 32'd0);
      if (exp_instr_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_instr: observed instr_pc %0h expected no instr_valid", instr_pc);
      end else begin
        logic [PC_W-1:0] e;
        e = exp_instr_q.pop_front();
        check("instr_pc", 32'(instr_pc), 32'(e));
        check("instr", instr, mk_word(e));
      end
    end
    prev_vld = (instr_valid === 1'b1);
  end

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (instr_valid === 1'b1) return;
    end
    checks++;
    errors++;
    $error("FAIL timeout_%s: observed no instr_valid expected one within 20 cycles", tag);
  endtask

  initial begin
    reset         = 1'b1;
    stall         = 1'b0;
    branch_req    = 1'b0;
    branch_offset = '0;
    mem_if.imem_ready = 1'b1;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check("rst_pc", 32'(pc), 32'(RST_PC));
    check("rst_instr_pc", 32'(instr_pc), 32'(RST_PC));
    check("rst_instr", instr, 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_req", 32'(mem_if.imem_req), 32'd0);

    // Straight-line fetch 0,4,8 with single-cycle memory.
    @(negedge clk);
    for (int a = 0; a <= 8; a += 4) begin
      exp_addr_q.push_back(PC_W'(a));
      exp_instr_q.push_back(PC_W'(a));
    end
    reset = 1'b1;
    #2 check("idle_no_req", 32'(mem_if.imem_req), 32'd0);
    repeat (3) wait_valid("seq");

    // Branch in FETCH after instr_pc=8: 8+196=204, no request this cycle.
    branch_req    = 1'b1;
    branch_offset = 20'd196;
    #2;
    check("br_fetch_no_req", 32'(mem_if.imem_req), 32'd0);
    check("br_fetch_pc_before", 32'(pc), 32'd12);
    @(negedge clk);
    branch_req = 1'b0;
    stall      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      check("stall_no_req", 32'(mem_if.imem_req), 32'd0);
      check("stall_pc_hold", 32'(pc), 32'd204);
      @(negedge clk);
    end
    stall = 1'b0;
    exp_addr_q.push_back(10'd204);
    exp_instr_q.push_back(10'd204);
    #2;
    check("resume_req", 32'(mem_if.imem_req), 32'd1);
    check("resume_addr", 32'(mem_if.imem_addr), 32'd204);
    wait_valid("br204");

    // Redirect to 12 (upper offset bits must be ignored: 204+0x340 = 1036 -> 12).
    branch_req    = 1'b1;
    branch_offset = 20'hFF340;
    #2 check("br2_no_req", 32'(mem_if.imem_req), 32'd0);
    @(negedge clk);
    branch_req = 1'b0;
    lat        = 2;
    exp_addr_q.push_back(10'd12);
    #2;
    check("addr12_req", 32'(mem_if.imem_req), 32'd1);
    check("addr12", 32'(mem_if.imem_addr), 32'd12);

    // Branch in WAIT before the response: 204+800 = 1004, response flushed.
    @(negedge clk);
    branch_req    = 1'b1;
    branch_offset = 20'd800;
    #2 check("wait_pc", 32'(pc), 32'd12);
    @(negedge clk);
    branch_req = 1'b0;
    lat        = 1;
    #2;
    check("flush_pc", 32'(pc), 32'd1004);
    check("flush_no_req", 32'(mem_if.imem_req), 32'd0);
    check("flush_no_valid", 32'(instr_valid), 32'd0);
    @(negedge clk);
    for (int a = 1004; a <= 1020; a += 4) begin
      exp_addr_q.push_back(PC_W'(a));
      exp_instr_q.push_back(PC_W'(a));
    end
    exp_addr_q.push_back(10'd0);
    #2;
    check("drop_no_valid", 32'(instr_valid), 32'd0);
    check("after_flush_addr", 32'(mem_if.imem_addr), 32'd1004);
    check("after_flush_req", 32'(mem_if.imem_req), 32'd1);
    repeat (5) wait_valid("wrap");
    #2;
    check("wrap_pc", 32'(pc), 32'd0);
    check("wrap_addr", 32'(mem_if.imem_addr), 32'd0);

    // Branch in WAIT coinciding with rvalid: 1020+16 wraps to 12, response dropped.
    @(negedge clk);
    branch_req    = 1'b1;
    branch_offset = 20'd16;
    @(negedge clk);
    branch_req = 1'b0;
    exp_addr_q.push_back(10'd12);
    exp_instr_q.push_back(10'd12);
    #2;
    check("same_cyc_no_valid", 32'(instr_valid), 32'd0);
    check("same_cyc_pc", 32'(pc), 32'd12);
    check("same_cyc_req", 32'(mem_if.imem_req), 32'd1);
    wait_valid("br12");

    // Reset while in WAIT; the stale response lands in IDLE after release.
    lat = 2;
    exp_addr_q.push_back(10'd16);
    @(negedge clk);
    reset = 1'b0;
    #2;
    check("midrst_req", 32'(mem_if.imem_req), 32'd0);
    check("midrst_pc", 32'(pc), 32'(RST_PC));
    check("midrst_instr_pc", 32'(instr_pc), 32'(RST_PC));
    check("midrst_instr", instr, 32'd0);
    check("midrst_valid", 32'(instr_valid), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    lat   = 1;
    #2 check("post_rst_idle", 32'(mem_if.imem_req), 32'd0);
    @(negedge clk);
    exp_addr_q.push_back(RST_PC);
    exp_instr_q.push_back(RST_PC);
    #2;
    check("stale_no_valid", 32'(instr_valid), 32'd0);
    check("post_rst_req", 32'(mem_if.imem_req), 32'd1);
    check("post_rst_addr", 32'(mem_if.imem_addr), 32'(RST_PC));
    wait_valid("post_rst");

    stall = 1'b1;
    repeat (3) @(negedge clk);
    check("addr_q_empty", 32'(exp_addr_q.size()), 32'd0);
    check("instr_q_empty", 32'(exp_instr_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
